// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite DMA engine and memory-bus arbiter between the CPU and shared memory.
// A CPU write of a page number to the trigger register stalls the CPU. The block then copies
// XFER_LEN bytes from {page,8'h00} into OAM and hands the bus back to the CPU.
module oam_dma_ctrl #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    REG_WIDTH    = 8,
    parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR = 16'h4014,
    parameter int                    XFER_LEN     = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_we,
    input  logic [REG_WIDTH-1:0]  cpu_wdata,
    output logic                  cpu_rdy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    output logic [7:0]            oam_addr,
    output logic [REG_WIDTH-1:0]  oam_wdata,
    output logic                  oam_we,
    output logic                  dma_busy
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [REG_WIDTH-1:0] page_q, page_d;
    logic [7:0]           idx_q, idx_d;
    logic                 parity_q;

    // State, latched page, byte index and the free-running even/odd cycle marker.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            page_q   <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            parity_q <= ~parity_q;
        end
    end

    // Next-state decode plus the bus mux and OAM strobes; the CPU owns the bus except in READ/WRITE.
    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        idx_d     = idx_q;
        cpu_rdy   = 1'b1;
        dma_busy  = 1'b0;
        oam_we    = 1'b0;
        oam_addr  = '0;
        oam_wdata = '0;
        mem_addr  = cpu_addr;
        mem_we    = cpu_we;

        case (state_q)
            S_IDLE: begin
                if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
                    page_d  = cpu_wdata;
                    idx_d   = '0;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                cpu_rdy  = 1'b0;
                dma_busy = 1'b1;
                // A 6502 keeps running write cycles regardless of rdy, so wait them out.
                // The first READ must land on an even cycle.
                if (!cpu_we) begin
                    state_d = parity_q ? S_READ : S_ALIGN;
                end
            end
            S_ALIGN: begin
                cpu_rdy  = 1'b0;
                dma_busy = 1'b1;
                state_d  = S_READ;
            end
            S_READ: begin
                cpu_rdy  = 1'b0;
                dma_busy = 1'b1;
                mem_addr = {page_q, idx_q};
                mem_we   = 1'b0;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                cpu_rdy   = 1'b0;
                dma_busy  = 1'b1;
                mem_addr  = {page_q, idx_q};
                mem_we    = 1'b0;
                oam_we    = 1'b1;
                oam_addr  = idx_q;
                oam_wdata = mem_rdata;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: self-checking bench for the sprite DMA controller with a synchronous memory model.
module tb_oam_dma_ctrl;

    logic        clk;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic        cpu_rdy;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic        dma_busy;

    logic [7:0]  mem [0:65535];

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } oamExp_t;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic        expRdy;
        logic        expBusy;
    } vec_t;

    oamExp_t expQ[$];
    vec_t    vecs[6];
    int      checkCount = 0;
    int      failCount  = 0;
    logic    tbParity;
    logic    zeroHit = 1'b0;

    oam_dma_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_wdata (cpu_wdata),
        .cpu_rdy   (cpu_rdy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .oam_addr  (oam_addr),
        .oam_wdata (oam_wdata),
        .oam_we    (oam_we),
        .dma_busy  (dma_busy)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared memory: synchronous read, data valid the cycle after the address.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= cpu_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Reference even/odd cycle marker, restarted by reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tbParity <= 1'b0;
        else          tbParity <= ~tbParity;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every OAM write pulse must match the next expected {index,data}.
    always @(negedge clk) begin
        oamExp_t e;
        if (reset_n && oam_we) begin
            if (expQ.size() == 0) begin
                checkCount++;
                failCount++;
                $display("[TB] FAIL oamUnexpected: pulse at oam_addr 0x%0h, expected none", oam_addr);
            end else begin
                e = expQ.pop_front();
                checkOutput("oamAddr", oam_addr, e.addr);
                checkOutput("oamData", oam_wdata, e.data);
                checkOutput("memWeDuringDma", mem_we, 1'b0);
            end
        end
        if (reset_n && dma_busy && mem_addr == 16'h0000) zeroHit = 1'b1;
    end

    task automatic applyStimulus(input logic [15:0] addr, input logic we, input logic [7:0] wdata);
        @(posedge clk);
        #1;
        cpu_addr  = addr;
        cpu_we    = we;
        cpu_wdata = wdata;
    endtask

    // Trigger one transfer and follow it to completion (or to an injected trigger / reset abort).
    task automatic runTransfer(input logic [7:0] page, input logic [7:0] key, input int hold,
                               input int wantParity, input int injectIdx, input int abortIdx);
        int   low;
        int   expLow;
        logic haltPar;
        bit   done;
        bit   aborted;
        @(posedge clk);
        #1;
        while (wantParity < 2 && tbParity != wantParity[0]) begin
            @(posedge clk);
            #1;
        end
        cpu_addr  = 16'h4014;
        cpu_we    = 1'b1;
        cpu_wdata = page;
        for (int i = 0; i < 256; i++) expQ.push_back({8'(i), 8'(i) ^ key});
        haltPar = ~tbParity ^ hold[0];
        expLow  = 1 + hold + (haltPar ? 0 : 1) + 512;
        low     = 0;
        done    = 0;
        aborted = 0;
        @(posedge clk);
        #1;
        for (int h = 0; h < hold; h++) begin
            cpu_wdata = page + 8'd1;
            @(negedge clk);
            checkOutput("holdMemAddr", mem_addr, 16'h4014);
            checkOutput("holdMemWe", mem_we, 1'b1);
            checkOutput("holdRdy", cpu_rdy, 1'b0);
            low++;
            @(posedge clk);
            #1;
        end
        cpu_we    = 1'b0;
        cpu_addr  = 16'h1234;
        cpu_wdata = 8'h00;
        while (!done) begin
            @(negedge clk);
            if (cpu_rdy) begin
                done = 1;
            end else begin
                low++;
                if (low > 2000) begin
                    checkCount++;
                    failCount++;
                    $display("[TB] FAIL transferTimeout: cpu_rdy low %0d cycles, limit 2000", low);
                    done = 1;
                end else if (oam_we && oam_addr == injectIdx) begin
                    #1;
                    cpu_addr  = 16'h4014;
                    cpu_we    = 1'b1;
                    cpu_wdata = 8'h05;
                    #1;
                    checkOutput("memWeIgnored", mem_we, 1'b0);
                    checkOutput("busyAtInject", dma_busy, 1'b1);
                    @(posedge clk);
                    #1;
                    cpu_we    = 1'b0;
                    cpu_addr  = 16'h1234;
                    cpu_wdata = 8'h00;
                end else if (oam_we && oam_addr == abortIdx) begin
                    #2;
                    reset_n = 1'b0;
                    #1;
                    checkOutput("abortRdy", cpu_rdy, 1'b1);
                    checkOutput("abortOamWe", oam_we, 1'b0);
                    checkOutput("abortBusy", dma_busy, 1'b0);
                    checkOutput("abortOamAddr", oam_addr, 8'h00);
                    checkOutput("abortMemAddr", mem_addr, 16'h1234);
                    aborted = 1;
                    done    = 1;
                end
            end
        end
        if (aborted) begin
            expQ.delete();
            @(posedge clk);
            #1;
            reset_n = 1'b1;
        end else begin
            checkOutput("rdyLowCycles", low, expLow);
            checkOutput("doneBusy", dma_busy, 1'b0);
            checkOutput("doneOamWe", oam_we, 1'b0);
            checkOutput("oamPulseCount", expQ.size(), 0);
            expQ.delete();
            @(posedge clk);
            #1;
            checkOutput("idleMemAddr", mem_addr, 16'h1234);
        end
    endtask

    // Main sequence: reset, pass-through table, then the multi-cycle transfer scenarios.
    initial begin
        vecs[0] = '{16'h4013, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[1] = '{16'h4015, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[2] = '{16'h4014, 1'b0, 8'h02, 1'b1, 1'b0};
        vecs[3] = '{16'h0010, 1'b1, 8'h77, 1'b1, 1'b0};
        vecs[4] = '{16'h4013, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{16'h1234, 1'b0, 8'h00, 1'b1, 1'b0};

        reset_n   = 1'b0;
        cpu_addr  = 16'h1234;
        cpu_we    = 1'b0;
        cpu_wdata = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
            mem[16'h0300 + i] = 8'(i) ^ 8'h5A;
            mem[16'hFF00 + i] = 8'(i) ^ 8'h3C;
        end
        mem[0] = 8'hEE;

        #12;
        checkOutput("resetRdy", cpu_rdy, 1'b1);
        checkOutput("resetBusy", dma_busy, 1'b0);
        checkOutput("resetOamWe", oam_we, 1'b0);
        checkOutput("resetOamAddr", oam_addr, 8'h00);
        checkOutput("resetOamData", oam_wdata, 8'h00);
        checkOutput("resetMemAddr", mem_addr, 16'h1234);
        checkOutput("resetMemWe", mem_we, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].addr, vecs[v].we, vecs[v].wdata);
            @(negedge clk);
            checkOutput("vecMemAddr", mem_addr, vecs[v].addr);
            checkOutput("vecMemWe", mem_we, vecs[v].we);
            checkOutput("vecRdy", cpu_rdy, vecs[v].expRdy);
            checkOutput("vecBusy", dma_busy, vecs[v].expBusy);
            checkOutput("vecOamWe", oam_we, 1'b0);
        end
        @(posedge clk);
        #1;
        checkOutput("passWriteMem", mem[16'h0010], 8'h77);

        $display("[TB] even-entry transfer, page 0x02");
        runTransfer(8'h02, 8'hA5, 0, 0, 999, 999);
        checkOutput("triggerReachedMem", mem[16'h4014], 8'h02);

        $display("[TB] odd-entry transfer through ALIGN, page 0x02");
        runTransfer(8'h02, 8'hA5, 0, 1, 999, 999);

        $display("[TB] trigger write held for 3 cycles");
        runTransfer(8'h02, 8'hA5, 3, 2, 999, 999);

        $display("[TB] reset abort at idx 100, then restart on page 0x03");
        runTransfer(8'h02, 8'hA5, 0, 2, 999, 100);
        runTransfer(8'h03, 8'h5A, 0, 2, 999, 999);

        $display("[TB] page 0xFF with a trigger injected during WRITE");
        runTransfer(8'hFF, 8'h3C, 0, 2, 50, 999);
        checkOutput("noWrapToZero", zeroHit, 1'b0);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
